// File: rtl/soc_vga_pkg.sv
// soc_vga_pkg: shared constants and helpers for the VGA scan-out block.
//   - 640x480@60 default timing (pixel clock ~25.175 MHz)
//   - RGB332 field positions inside a framebuffer byte
//   - expand(): RGB332 byte -> 4:4:4 colour by MSB replication
package soc_vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // RGB332 byte layout {r[2:0], g[2:0], b[1:0]}
  localparam int RGB_R_MSB = 7;
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_MSB = 1;
  localparam int RGB_B_LSB = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Replicate MSBs so full-scale input maps to full-scale output (7 -> F, 3 -> F).
  function automatic rgb444_t expand(input logic [7:0] px);
    logic [2:0] r3;
    logic [2:0] g3;
    logic [1:0] b2;
    rgb444_t    o;
    r3  = px[RGB_R_MSB:RGB_R_LSB];
    g3  = px[RGB_G_MSB:RGB_G_LSB];
    b2  = px[RGB_B_MSB:RGB_B_LSB];
    o.r = {r3, r3[2]};
    o.g = {g3, g3[2]};
    o.b = {b2, b2};
    return o;
  endfunction

endpackage

// File: rtl/soc_vga_delay_line.sv
// soc_vga_delay_line: DEPTH-stage shift register, WIDTH bits per stage.
//   gclk   in  clock
//   grst_n in  async active-low reset; every stage loads RESET_VALUE
//   d      in  WIDTH  stage-0 input
//   q      out WIDTH  input delayed by DEPTH clocks
module soc_vga_delay_line #(
  parameter int                WIDTH       = 1,
  parameter int                DEPTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VALUE;
    end else begin
      r_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign q = r_pipe[DEPTH-1];

endmodule

// File: rtl/soc_vga_scanout.sv
// soc_vga_scanout: VGA timing generator and framebuffer scan-out (vga_clk domain).
//   vga_clk      in   pixel clock
//   res_n        in   async active-low reset
//   enable       in   1 = show framebuffer, 0 = black (timing unaffected)
//   word_addr_b  out  byte address to framebuffer read port B
//   read_data_b  in   RGB332 byte, MEM_LATENCY clocks after word_addr_b
//   vga_r/g/b    out  4-bit colour channels
//   vga_hs/vs    out  syncs, asserted level HS_POL / VS_POL
//   frame_start  out  one-clock pulse with pixel (0,0) on the colour outputs
// Pipeline: stage 0 counters -> stage 1 address -> stage 1+MEM_LATENCY data
// -> stage PIPE registered colour. Side-band timing rides a delay line so
// everything on the pins belongs to the same pixel.
module soc_vga_scanout import soc_vga_pkg::*; #(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE       = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  vga_clk,
  input  logic                  res_n,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] word_addr_b,
  input  logic [7:0]            read_data_b,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int PIPE    = 2 + MEM_LATENCY;
  localparam int FB_W    = H_ACTIVE >> SCALE;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  // Low SCALE bits of v_cnt all ones = last replica of a framebuffer row.
  localparam logic [VW-1:0] V_REP_MASK = VW'((1 << SCALE) - 1);
  localparam logic [ADDR_WIDTH-1:0] FB_W_A = ADDR_WIDTH'(FB_W);

  logic [HW-1:0]         r_h_cnt;
  logic [VW-1:0]         r_v_cnt;
  logic [ADDR_WIDTH-1:0] r_line_base;
  logic [ADDR_WIDTH-1:0] r_addr;
  rgb444_t               r_rgb;

  logic w_h_wrap, w_v_wrap, w_row_step;
  logic w_active, w_hs_raw, w_vs_raw, w_fs_raw;
  logic w_act_d, w_en_d;

  // Stage 0 decode
  assign w_h_wrap   = (r_h_cnt == H_LAST);
  assign w_v_wrap   = w_h_wrap && (r_v_cnt == V_LAST);
  assign w_row_step = w_h_wrap && (r_v_cnt < V_ACT) &&
                      ((r_v_cnt & V_REP_MASK) == V_REP_MASK);
  assign w_active   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_raw   = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign w_vs_raw   = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign w_fs_raw   = (r_h_cnt == '0) && (r_v_cnt == '0);

  always_ff @(posedge vga_clk or negedge res_n) begin
    if (!res_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_line_base <= '0;
      r_addr      <= '0;
    end else begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
      // Frame wrap wins over the row step on the last line's wrap edge.
      if (w_v_wrap)        r_line_base <= '0;
      else if (w_row_step) r_line_base <= r_line_base + FB_W_A;
      // Stage 1: running row base avoids a v*FB_W multiplier.
      r_addr <= w_active ? r_line_base + ADDR_WIDTH'(r_h_cnt >> SCALE) : '0;
    end
  end

  assign word_addr_b = r_addr;

  // active/enable are consumed by the colour register, so they need one
  // stage less than the pins.
  soc_vga_delay_line #(
    .WIDTH(2), .DEPTH(PIPE - 1), .RESET_VALUE(2'b00)
  ) u_dl_pix (
    .gclk(vga_clk), .grst_n(res_n),
    .d({w_active, enable}), .q({w_act_d, w_en_d})
  );

  // Polarity is applied before the delay so reset loads the idle sync level
  // and the delay output drives the pins directly.
  soc_vga_delay_line #(
    .WIDTH(3), .DEPTH(PIPE), .RESET_VALUE({~HS_POL, ~VS_POL, 1'b0})
  ) u_dl_sync (
    .gclk(vga_clk), .grst_n(res_n),
    .d({w_hs_raw ? HS_POL : ~HS_POL, w_vs_raw ? VS_POL : ~VS_POL, w_fs_raw}),
    .q({vga_hs, vga_vs, frame_start})
  );

  always_ff @(posedge vga_clk or negedge res_n) begin
    if (!res_n)                r_rgb <= '0;
    else if (w_act_d && w_en_d) r_rgb <= expand(read_data_b);
    else                       r_rgb <= '0;
  end

  assign vga_r = r_rgb.r;
  assign vga_g = r_rgb.g;
  assign vga_b = r_rgb.b;

endmodule

// File: doc/soc_vga_scanout.md
Name: soc_vga_scanout

Overview:
- VGA scan-out engine in the vga_clk domain, directly downstream of the framebuffer's read-only byte port B.
- Generates horizontal/vertical timing and drives the byte address into the framebuffer.
- Consumes the returned RGB332 pixel byte and outputs 4:4:4 RGB plus HS/VS, all pipeline-aligned.
- Supports integer pixel doubling (SCALE), so a smaller framebuffer can fill the screen.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level
VS_POL, 0, vsync asserted level
SCALE, 1, log2 pixel replication factor; framebuffer width FB_W = H_ACTIVE>>SCALE
ADDR_WIDTH, 32, framebuffer byte address width
MEM_LATENCY, 1, framebuffer port-B read latency (clocks)

Ports:
vga_clk  in  1  pixel clock; the only clock
res_n  in  1  reset, asynchronous, active-low
enable  in  1  1 = show framebuffer, 0 = output black (timing keeps running)
word_addr_b  out  ADDR_WIDTH  byte address to framebuffer port B
read_data_b  in  8  pixel byte from framebuffer, RGB332 {r[2:0],g[2:0],b[1:0]}
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
frame_start  out  1  one-clock pulse coincident with pixel (0,0) on the RGB outputs

Behaviour:
- Reset (async assert on res_n=0, released synchronously to the pipeline):
  - h_cnt=0, v_cnt=0, line_base=0, word_addr_b=0, rgb=0, frame_start=0.
  - vga_hs=~HS_POL, vga_vs=~VS_POL.
  - All delay-line stages cleared to inactive.
- Counters (stage 0):
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters. It wraps to 0 and v_cnt increments on wrap.
  - v_cnt runs 0..V_TOTAL-1 and wraps to 0 when h_cnt wraps on line V_TOTAL-1.
- Timing decode from stage 0:
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hs_raw asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw uses the same form on v_cnt.
  - fs_raw = (h_cnt==0 && v_cnt==0).
- Address generation (no multiplier):
  - line_base is incremented by FB_W at the h_cnt wrap of visible line v when v[SCALE-1:0] is all ones (with SCALE=0: every visible line).
  - line_base is cleared at the v_cnt wrap.
  - Stage 1 register: word_addr_b = active ? line_base + (h_cnt>>SCALE) : 0.
- Data return: read_data_b is valid MEM_LATENCY clocks after word_addr_b. That puts pixel data at stage 1+MEM_LATENCY.
- Output stage (stage PIPE = 2+MEM_LATENCY, registered):
  - If active_d && enable_d: vga_r={r3,r3[2]}, vga_g={g3,g3[2]}, vga_b={b2,b2}.
  - Otherwise all three channels are 0.
- Alignment:
  - active, enable, hs_raw, vs_raw and fs_raw enter a PIPE-deep delay line at stage 0.
  - vga_hs/vga_vs are driven as POL when delayed raw=1, else ~POL.
  - frame_start is fs_raw delayed by PIPE.
- Latency: pixel (h,v) appears on the outputs PIPE clocks after the counters hold (h,v). With defaults this is 3.
- After reset release, the 3rd rising edge presents pixel (0,0) with frame_start=1.
- enable change: takes effect for the pixel at stage 0 on that clock. Never alters sync timing.
- Reset mid-frame: everything returns to reset values immediately. Scan restarts at (0,0) with no partial-line artefacts beyond the reset point.
- Boundaries:
  - h_cnt wrap and v_cnt wrap on the same edge: line_base clears; the v_cnt clear takes priority over the line_base increment.
  - The final framebuffer address in a frame is (V_ACTIVE>>SCALE)*FB_W-1.

Decomposition:
- soc_vga_pkg holds the 640x480@60 default timing constants, the RGB332 field positions, and an expand function.
- One sub-module: soc_vga_delay_line (parameterised WIDTH and DEPTH shift register, async active-low reset to a RESET_VALUE parameter). It is used for the sync/active/enable/frame_start alignment.

Test Plan:
Shared test config: H 8/2/3/3 (H_TOTAL=16), V 4/1/2/1 (V_TOTAL=8), SCALE=0, MEM_LATENCY=1, memory model byte[a]=a.
1. Reset release -> word_addr_b sequence 0..7 on line 0, then 0 during blanking, then 8..15 on line 1. RGB pixel (0,0) is on the 3rd edge after release, with frame_start=1 for exactly one clock.
2. Sync timing -> vga_hs low for 3 clocks starting 10 clocks after the first pixel of each line. vga_vs low for 2 lines (32 clocks) starting on line 5. Frame period 128 clocks.
3. RGB expansion with the memory forced to a constant: 0xE3 -> r=F,g=0,b=F; 0x92 -> r=9,g=9,b=A. Blanking outputs 0.
4. SCALE=1 -> line 0 addresses 0,0,1,1,2,2,3,3; line 1 repeats the same; line 2 gives 4,4,5,5,...; last visible address is 7.
5. enable dropped for 4 clocks mid-line -> exactly those 4 pixels black (shifted by PIPE); hs/vs unchanged.
6. res_n pulsed low mid-line 2 -> outputs go to reset values asynchronously. After release, frame_start occurs on the 3rd edge and addresses restart at 0.
